// File: rtl/jedro_1_mem_arbiter_pkg.sv
// Shared types for the jedro_1 instruction/data RAM arbiter.
// Latency: n/a (types, constants and a tag builder only).
// Backpressure: n/a.
package jedro_1_mem_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_write;
  } arb_tag_t;

  localparam int MAX_RD_LATENCY = 4;

  // Builds the tag recorded for the access issued this cycle.
  function automatic arb_tag_t make_tag(input logic i_win, input logic d_win, input logic we);
    arb_tag_t t;
    t.valid    = i_win | d_win;
    t.owner    = d_win ? OWN_D : (i_win ? OWN_I : OWN_NONE);
    t.is_write = d_win & we;
    return t;
  endfunction

endpackage

// File: rtl/jedro_1_mem_arbiter_if.sv
// Bundle of the instr port, data port and RAM port seen by the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req is held by the requester until its gnt is seen high.
interface jedro_1_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                    i_req_i;
  logic [ADDR_WIDTH-1:0]   i_addr_i;
  logic                    i_gnt_o;
  logic                    i_rvalid_o;
  logic [DATA_WIDTH-1:0]   i_rdata_o;

  logic                    d_req_i;
  logic                    d_we_i;
  logic [DATA_WIDTH/8-1:0] d_be_i;
  logic [ADDR_WIDTH-1:0]   d_addr_i;
  logic [DATA_WIDTH-1:0]   d_wdata_i;
  logic                    d_gnt_o;
  logic                    d_rvalid_o;
  logic [DATA_WIDTH-1:0]   d_rdata_o;

  logic                    ram_en_o;
  logic [DATA_WIDTH/8-1:0] ram_we_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic [DATA_WIDTH-1:0]   ram_wdata_o;
  logic [DATA_WIDTH-1:0]   ram_rdata_i;

  // Arbiter side.
  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  ram_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  // Requester and RAM side.
  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output ram_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

endinterface

// File: rtl/jedro_1_mem_arbiter_tag_pipe.sv
// Shift register carrying the owner tag of each issued RAM access.
// Latency: DEPTH cycles from issue_tag to resp_tag.
// Backpressure: none, advances every cycle; sync active-low clear drops everything in flight.
module jedro_1_mem_arb_tag_pipe
  import jedro_1_mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rstn,
  input  arb_tag_t issue_tag,
  output arb_tag_t resp_tag
);

  arb_tag_t stage [DEPTH];

  // Shift tags one stage per cycle; clearing on reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= issue_tag;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign resp_tag = stage[DEPTH-1];

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one single-port sync RAM between the jedro_1 instr-fetch and load/store ports.
// Latency: zero-cycle grant; response exactly RD_LATENCY cycles after grant, in order, 1/cycle.
// Backpressure: loser sees gnt low and holds req; JEDRO_1_ARB_RR_EN selects round-robin over fixed data priority.
module jedro_1_mem_arbiter
  import jedro_1_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  jedro_1_mem_arbiter_if.slave bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  // Out-of-range latencies are clamped so the tag pipe is always legal.
  localparam int LAT = (RD_LATENCY < 1) ? 1 :
                       (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;

  logic                  i_gnt;
  logic                  d_gnt;
  logic                  i_rvalid;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic [BE_WIDTH-1:0]   ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  arb_tag_t              issue_tag;
  arb_tag_t              resp_tag;

`ifdef JEDRO_1_ARB_RR_EN
  owner_e last_owner;
`else
  localparam int                   CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STARVE_LIMIT);
  logic [CNT_WIDTH-1:0]            stall_cnt;
`endif

  // Pick at most one winner; a lone requester always wins, nothing is granted in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rstn_i) begin
      if (bus.i_req_i && bus.d_req_i) begin
`ifdef JEDRO_1_ARB_RR_EN
        if (last_owner == OWN_I) d_gnt = 1'b1;
        else                     i_gnt = 1'b1;
`else
        if (stall_cnt == CNT_MAX) i_gnt = 1'b1;
        else                      d_gnt = 1'b1;
`endif
      end else begin
        i_gnt = bus.i_req_i;
        d_gnt = bus.d_req_i;
      end
    end
  end

`ifdef JEDRO_1_ARB_RR_EN
  // Remember who won last so the other port takes the next contended cycle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)    last_owner <= OWN_NONE;
    else if (i_gnt) last_owner <= OWN_I;
    else if (d_gnt) last_owner <= OWN_D;
  end
`else
  // Count consecutive cycles instr waits; saturation forces an instr win.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      stall_cnt <= '0;
    end else if (bus.i_req_i && !i_gnt) begin
      if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end else begin
      stall_cnt <= '0;
    end
  end
`endif

  // RAM port follows the winner in the same cycle.
  assign ram_we    = (d_gnt && bus.d_we_i) ? bus.d_be_i : '0;
  assign ram_addr  = d_gnt ? bus.d_addr_i : bus.i_addr_i;
  assign ram_wdata = d_gnt ? bus.d_wdata_i : '0;

  assign bus.i_gnt_o     = i_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.ram_en_o    = i_gnt | d_gnt;
  assign bus.ram_we_o    = ram_we;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_wdata_o = ram_wdata;

  assign issue_tag = make_tag(i_gnt, d_gnt, bus.d_we_i);

  jedro_1_mem_arb_tag_pipe #(
    .DEPTH (LAT)
  ) u_tag_pipe (
    .clk       (clk_i),
    .rstn      (rstn_i),
    .issue_tag (issue_tag),
    .resp_tag  (resp_tag)
  );

  // Route RAM read data back to the tagged owner; idle and write responses read as 0.
  assign i_rvalid = resp_tag.valid && (resp_tag.owner == OWN_I);
  assign d_rvalid = resp_tag.valid && (resp_tag.owner == OWN_D);
  assign i_rdata  = i_rvalid ? bus.ram_rdata_i : '0;
  assign d_rdata  = (d_rvalid && !resp_tag.is_write) ? bus.ram_rdata_i : '0;

  assign bus.i_rvalid_o = i_rvalid;
  assign bus.i_rdata_o  = i_rdata;
  assign bus.d_rvalid_o = d_rvalid;
  assign bus.d_rdata_o  = d_rdata;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Bench for jedro_1_mem_arbiter: two instances (RD_LATENCY 1 and 3) share the same requests.
// A scoreboard predicts grants, RAM port values and per-owner responses from the arbitration rules.
// RAM is modelled as a word array with a read pipeline matching each instance's latency.
module tb_jedro_1_mem_arbiter;

  localparam int SL = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_req   = 1'b0;
  logic [31:0] i_addr  = '0;
  logic        d_req   = 1'b0;
  logic        d_we    = 1'b0;
  logic [3:0]  d_be    = '0;
  logic [31:0] d_addr  = '0;
  logic [31:0] d_wdata = '0;

  jedro_1_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  jedro_1_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  assign bus1.i_req_i = i_req;   assign bus3.i_req_i = i_req;
  assign bus1.i_addr_i = i_addr; assign bus3.i_addr_i = i_addr;
  assign bus1.d_req_i = d_req;   assign bus3.d_req_i = d_req;
  assign bus1.d_we_i = d_we;     assign bus3.d_we_i = d_we;
  assign bus1.d_be_i = d_be;     assign bus3.d_be_i = d_be;
  assign bus1.d_addr_i = d_addr; assign bus3.d_addr_i = d_addr;
  assign bus1.d_wdata_i = d_wdata; assign bus3.d_wdata_i = d_wdata;

  jedro_1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1), .STARVE_LIMIT(SL))
    dut1 (.clk_i(clk), .rstn_i(rstn), .bus(bus1));
  jedro_1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3), .STARVE_LIMIT(SL))
    dut3 (.clk_i(clk), .rstn_i(rstn), .bus(bus3));

  // RAM environment: writes come from the latency-1 instance; reads pipelined per instance.
  logic [31:0] env_mem [64] = '{default: 32'h0};
  logic [31:0] rd1;
  logic [31:0] rd3 [3];
  always @(posedge clk) begin
    if (bus1.ram_en_o)
      for (int k = 0; k < 4; k++)
        if (bus1.ram_we_o[k]) env_mem[bus1.ram_addr_o[7:2]][8*k +: 8] <= bus1.ram_wdata_o[8*k +: 8];
    rd1    <= (bus1.ram_en_o && bus1.ram_we_o == 4'h0) ? env_mem[bus1.ram_addr_o[7:2]] : $urandom;
    rd3[0] <= (bus3.ram_en_o && bus3.ram_we_o == 4'h0) ? env_mem[bus3.ram_addr_o[7:2]] : $urandom;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign bus1.ram_rdata_i = rd1;
  assign bus3.ram_rdata_i = rd3[2];

  // Reference model state.
  typedef struct {
    int          due;
    bit          to_i;
    logic [31:0] data;
  } rsp_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          deny_run = 0;
  int          last_win = 0;   // 0 none, 1 instr, 2 data
  logic [31:0] ref_mem [64];
  rsp_t        q1[$];
  rsp_t        q3[$];
  bit          g_i, g_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_rsp(input string nm, input bit have, input rsp_t e,
                            input logic iv, input logic [31:0] id,
                            input logic dv, input logic [31:0] dd);
    logic        eiv, edv;
    logic [31:0] eid, edd;
    eiv = have && e.to_i;
    edv = have && !e.to_i;
    eid = eiv ? e.data : 32'h0;
    edd = edv ? e.data : 32'h0;
    chk({nm, "_i_rvalid"}, iv, eiv);
    chk({nm, "_i_rdata"},  id, eid);
    chk({nm, "_d_rvalid"}, dv, edv);
    chk({nm, "_d_rdata"},  dd, edd);
  endtask

  // One cycle of prediction and comparison, sampled at the falling edge.
  task automatic step(output bit gi, output bit gd);
    rsp_t        e;
    bit          have;
    logic [3:0]  we_exp;
    logic [31:0] a_exp;
    gi = 1'b0;
    gd = 1'b0;
    if (rstn) begin
      if (i_req && d_req) begin
`ifdef JEDRO_1_ARB_RR_EN
        gd = (last_win == 1);
`else
        gd = (deny_run < SL);
`endif
        gi = !gd;
      end else begin
        gi = i_req;
        gd = d_req;
      end
    end
    we_exp = (gd && d_we) ? d_be : 4'h0;
    a_exp  = gd ? d_addr : i_addr;
    chk("i_gnt", bus1.i_gnt_o, gi);
    chk("d_gnt", bus1.d_gnt_o, gd);
    chk("i_gnt_l3", bus3.i_gnt_o, gi);
    chk("d_gnt_l3", bus3.d_gnt_o, gd);
    chk("ram_en", bus1.ram_en_o, gi | gd);
    chk("ram_we", bus1.ram_we_o, we_exp);
    chk("ram_en_l3", bus3.ram_en_o, gi | gd);
    chk("ram_we_l3", bus3.ram_we_o, we_exp);
    if (gi || gd) begin
      chk("ram_addr", bus1.ram_addr_o, a_exp);
      chk("ram_addr_l3", bus3.ram_addr_o, a_exp);
    end
    if (gd && d_we) begin
      chk("ram_wdata", bus1.ram_wdata_o, d_wdata);
      chk("ram_wdata_l3", bus3.ram_wdata_o, d_wdata);
    end
    if (rstn) begin
      have = (q1.size() > 0) && (q1[0].due == cyc);
      if (have) e = q1.pop_front();
      expect_rsp("l1", have, e, bus1.i_rvalid_o, bus1.i_rdata_o, bus1.d_rvalid_o, bus1.d_rdata_o);
      have = (q3.size() > 0) && (q3[0].due == cyc);
      if (have) e = q3.pop_front();
      expect_rsp("l3", have, e, bus3.i_rvalid_o, bus3.i_rdata_o, bus3.d_rvalid_o, bus3.d_rdata_o);
    end
    if (!rstn) begin
      q1.delete();
      q3.delete();
      deny_run = 0;
      last_win = 0;
    end else begin
      if (gi || gd) begin
        e.to_i = gi;
        e.data = gi ? ref_mem[i_addr[7:2]] : (d_we ? 32'h0 : ref_mem[d_addr[7:2]]);
        e.due  = cyc + 1;
        q1.push_back(e);
        e.due  = cyc + 3;
        q3.push_back(e);
        if (gd && d_we)
          for (int k = 0; k < 4; k++)
            if (d_be[k]) ref_mem[d_addr[7:2]][8*k +: 8] = d_wdata[8*k +: 8];
      end
      if (i_req && !gi) deny_run = (deny_run < SL) ? deny_run + 1 : SL;
      else              deny_run = 0;
      if (gi)      last_win = 1;
      else if (gd) last_win = 2;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step(g_i, g_d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_i(input logic [31:0] a);
    i_req  = 1'b1;
    i_addr = a;
    d_req  = 1'b0;
    tick();
  endtask

  task automatic do_d(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    i_req   = 1'b0;
    d_req   = 1'b1;
    d_we    = we;
    d_be    = be;
    d_addr  = a;
    d_wdata = wd;
    tick();
  endtask

  task automatic new_d();
    d_we    = $urandom_range(0, 1);
    d_be    = 4'($urandom_range(0, 15));
    d_addr  = $urandom & 32'hFFFF_FFFC;
    d_wdata = $urandom;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) ref_mem[k] = 32'h0;

    // Reset with both requests high: nothing may be granted.
    rstn = 1'b0; i_req = 1'b1; d_req = 1'b1;
    i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'h1234;
    tick();
    tick();
    rstn = 1'b1;
    idle(2);

    // Fill memory through the data port, leaving word 0x10 at its preset 0.
    for (int k = 0; k < 64; k++)
      if (k != 4) do_d(1'b1, 4'hF, 32'(k * 4), $urandom);
    idle(4);

    // Instr-only back-to-back fetches.
    do_i(32'h0);
    do_i(32'h4);
    do_i(32'h8);
    idle(4);

    // Partial write then read back of 0x10.
    do_d(1'b1, 4'b0011, 32'h10, 32'hDEADBEEF);
    do_d(1'b0, 4'h0, 32'h10, 32'h0);
    chk("t2_readback", bus1.d_rdata_o, 32'h0000BEEF);
    idle(4);

    // Sustained contention: both requests held high.
    i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
    d_req = 1'b1; new_d();
    for (int k = 0; k < 20; k++) begin
      #1;
`ifdef JEDRO_1_ARB_RR_EN
      chk("contend_pattern", bus1.i_gnt_o, (k % 2) == 0);
`else
      chk("contend_pattern", bus1.i_gnt_o, (k % 5) == 4);
`endif
      tick();
      if (g_i) i_addr = $urandom & 32'hFFFF_FFFC;
      if (g_d) new_d();
    end
    idle(4);

    // Random traffic with held and cancelled requests.
    g_i = 1'b0; g_d = 1'b0;
    repeat (600) begin
      if (i_req && !g_i) begin
        if ($urandom_range(0, 7) == 0) i_req = 1'b0;
      end else begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (d_req && !g_d) begin
        if ($urandom_range(0, 7) == 0) d_req = 1'b0;
      end else begin
        d_req = ($urandom_range(0, 2) != 0);
        new_d();
      end
      tick();
    end
    idle(4);

    // Reset while two reads are in flight, then a fresh fetch.
    do_i(32'h20);
    do_d(1'b0, 4'h0, 32'h24, 32'h0);
    rstn = 1'b0; i_req = 1'b0; d_req = 1'b0;
    tick();
    rstn = 1'b1;
    idle(5);
    do_i(32'h28);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
